ysyx_201979054_mdu: RTL

Iterative, parametrised RISC-V M-extension unit (multiply, divide, remainder, including RV64 word forms) executing one result bit per cycle behind a valid/ready handshake. It sits beside the single-cycle ALU in the execute stage. The core's control FSM stalls on `o_ready`/`o_valid`, while the ALU decoder forwards `func_3` and the word flag for M-ext opcodes.

---
 rtl/ysyx_201979054_mdu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_201979054_mdu.sv
// Iterative RISC-V M-extension unit: MUL/MULH*/DIV*/REM* plus RV64 word forms, one bit per cycle.
// Latency: N+2 cycles from the accept cycle to the o_valid cycle (N=32 word / XLEN full); 1 cycle for div-by-zero, overflow, word MULH*.
// Backpressure: accepts only while o_ready (IDLE); o_valid is a single-cycle pulse with no stall, so the consumer must take it.
module ysyx_201979054_mdu #(
   parameter int XLEN = 64
) (
   input  logic            i_clk,
   input  logic            i_arst,
   input  logic            i_valid,
   input  logic [2:0]      i_func_3,
   input  logic            i_word,
   input  logic [XLEN-1:0] i_src_a,
   input  logic [XLEN-1:0] i_src_b,
   input  logic            i_flush,
   output logic            o_ready,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt;
   // mul: r_acc = product, r_mc = shifted multiplicand, r_b = multiplier (shifts right)
   // div: r_acc[XLEN-1:0] = partial remainder, r_mc[XLEN-1:0] = divisor, r_b = dividend in / quotient out
   logic [2*XLEN-1:0] r_acc, r_mc;
   logic [XLEN-1:0]   r_b;
   logic [2:0]        r_func;
   logic              r_word, r_neg, r_neg_r;
   logic [XLEN-1:0]   r_result;

   function automatic logic [XLEN-1:0] sx32(input logic [31:0] x);
      logic signed [31:0] s;
      s = signed'(x);
      return XLEN'(s);
   endfunction

   function automatic logic [XLEN-1:0] zx32(input logic [31:0] x);
      return XLEN'(x);
   endfunction

   // Word forms only exist on RV64.
   logic            w_word, w_is_div, w_sa, w_sb, w_a_neg, w_b_neg;
   logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_n_min;
   logic            w_div0, w_ovf, w_mulh_w, w_special, w_accept;
   logic [XLEN-1:0] w_spec_raw, w_spec_res;

   assign w_word   = (XLEN == 64) ? i_word : 1'b0;
   assign w_is_div = i_func_3[2];
   // Operand signedness: MUL/MULH/MULHSU treat rs1 signed, MUL/MULH treat rs2 signed.
   assign w_sa     = w_is_div ? ~i_func_3[0] : (i_func_3[1:0] != 2'b11);
   assign w_sb     = w_is_div ? ~i_func_3[0] : ~i_func_3[1];
   assign w_a_ext  = w_word ? (w_sa ? sx32(i_src_a[31:0]) : zx32(i_src_a[31:0])) : i_src_a;
   assign w_b_ext  = w_word ? (w_sb ? sx32(i_src_b[31:0]) : zx32(i_src_b[31:0])) : i_src_b;
   assign w_a_neg  = w_sa & w_a_ext[XLEN-1];
   assign w_b_neg  = w_sb & w_b_ext[XLEN-1];
   // Magnitude of the most-negative value stays 100..0, which is correct read as unsigned.
   assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
   assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
   assign w_n_min  = w_word ? ~zx32(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};

   assign w_div0    = w_is_div & (w_b_ext == '0);
   assign w_ovf     = w_is_div & ~i_func_3[0] & (w_a_ext == w_n_min) & (&w_b_ext);
   assign w_mulh_w  = ~w_is_div & w_word & (i_func_3[1:0] != 2'b00);
   assign w_special = w_div0 | w_ovf | w_mulh_w;
   assign w_accept  = (r_state == S_IDLE) & i_valid & ~i_flush;

   // Shortcut results; func_3[1] distinguishes REM* from DIV*.
   always_comb begin
      w_spec_raw = '0;
      if (w_mulh_w)    w_spec_raw = '0;
      else if (w_div0) w_spec_raw = i_func_3[1] ? w_a_ext : '1;
      else if (w_ovf)  w_spec_raw = i_func_3[1] ? '0 : w_a_ext;
   end
   assign w_spec_res = w_word ? sx32(w_spec_raw[31:0]) : w_spec_raw;

   // Iteration datapath.
   logic [2*XLEN-1:0] w_add;
   logic [XLEN:0]     w_shift, w_trial;
   assign w_add   = r_acc + (r_b[0] ? r_mc : '0);
   assign w_shift = {r_acc[XLEN-1:0], r_b[XLEN-1]};
   assign w_trial = w_shift - {1'b0, r_mc[XLEN-1:0]};

   // Sign fix-up and result selection.
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot, w_rem, w_sel, w_fix_res;
   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_quot = r_neg ? -r_b : r_b;
   assign w_rem  = r_neg_r ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];

   // Pick product half, quotient or remainder by op.
   always_comb begin
      w_sel = w_rem;
      case (r_func)
         3'b000:                 w_sel = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_sel = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_sel = w_quot;
         default:                w_sel = w_rem;
      endcase
   end
   assign w_fix_res = r_word ? sx32(w_sel[31:0]) : w_sel;

   // State register.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode; flush overrides everything including a same-cycle accept.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_CALC;
         S_CALC:  if (r_cnt == '0) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (i_flush) w_next = S_IDLE;
   end

   // Operand capture, per-cycle shift-add / restoring step, and result register.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mc     <= '0;
         r_b      <= '0;
         r_func   <= '0;
         r_word   <= 1'b0;
         r_neg    <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_cnt   <= w_word ? CW'(31) : CW'(XLEN-1);
         r_func  <= i_func_3;
         r_word  <= w_word;
         r_neg   <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_acc   <= '0;
         if (w_is_div) begin
            r_mc <= {{XLEN{1'b0}}, w_b_mag};
            // Left-align a 32-bit dividend so the MSB-first loop sees it first.
            r_b  <= w_word ? (w_a_mag << (XLEN-32)) : w_a_mag;
         end else begin
            r_mc <= {{XLEN{1'b0}}, w_a_mag};
            r_b  <= w_b_mag;
         end
         if (w_special) r_result <= w_spec_res;
      end else if (r_state == S_CALC) begin
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         if (r_func[2]) begin
            if (!w_trial[XLEN]) begin
               r_acc[XLEN-1:0] <= w_trial[XLEN-1:0];
               r_b             <= {r_b[XLEN-2:0], 1'b1};
            end else begin
               r_acc[XLEN-1:0] <= w_shift[XLEN-1:0];
               r_b             <= {r_b[XLEN-2:0], 1'b0};
            end
         end else begin
            r_acc <= w_add;
            r_mc  <= r_mc << 1;
            r_b   <= r_b >> 1;
         end
      end else if ((r_state == S_FIX) && !i_flush) begin
         r_result <= w_fix_res;
      end
   end

   assign o_ready  = (r_state == S_IDLE);
   assign o_valid  = (r_state == S_DONE);
   assign o_result = r_result;

endmodule
